// File: rtl/instruction_memory_responder.sv
// Instruction memory responder: word-addressed 16-bit store answering each
// new fetch address after a fixed latency, with a load port for the image.
module instruction_memory_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  output logic [15:0] memdat,
  output logic        wt,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        err
);

  typedef enum logic {
    FETCH,
    READY
  } state_t;

  localparam int unsigned DEPTH     = 1 << ADDR_BITS;
  localparam logic [3:0]  CNT_START = 4'(LATENCY - 1);

  logic [15:0] store [0:DEPTH-1];

  state_t      state, state_nx;
  logic [31:0] served_addr, served_addr_nx;
  logic        served_valid, served_valid_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [15:0] memdat_nx;
  logic        err_nx;

  logic        collide;
  logic        accept;
  logic        served_oor;
  logic        ld_oor;
  logic [15:0] rd_data;

  // A load to the served address invalidates the fetch, just like a new address.
  assign collide    = ld_en && (ld_addr == served_addr);
  assign accept     = !served_valid || (addr != served_addr) || collide;
  assign served_oor = (served_addr >> ADDR_BITS) != 32'd0;
  assign ld_oor     = (ld_addr >> ADDR_BITS) != 32'd0;
  assign rd_data    = served_oor ? 16'hFFFF : store[served_addr[ADDR_BITS-1:0]];
  assign wt         = (state != READY) || (addr != served_addr) || collide;

  // Program image writes; the store is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (ld_en && !ld_oor) begin
      store[ld_addr[ADDR_BITS-1:0]] <= ld_data;
    end
  end

  // State register for the fetch sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      served_addr  <= '0;
      served_valid <= 1'b0;
      cnt          <= '0;
      memdat       <= '0;
      err          <= 1'b0;
    end else begin
      state        <= state_nx;
      served_addr  <= served_addr_nx;
      served_valid <= served_valid_nx;
      cnt          <= cnt_nx;
      memdat       <= memdat_nx;
      err          <= err_nx;
    end
  end

  // Next-state: acceptance restarts the latency; completion latches read data.
  always_comb begin
    state_nx        = state;
    served_addr_nx  = served_addr;
    served_valid_nx = served_valid;
    cnt_nx          = cnt;
    memdat_nx       = memdat;
    err_nx          = err;

    if (ld_en && ld_oor) begin
      err_nx = 1'b1;
    end

    if (accept) begin
      served_addr_nx  = addr;
      served_valid_nx = 1'b1;
      state_nx        = FETCH;
      cnt_nx          = CNT_START;
    end else if (state == FETCH) begin
      if (cnt != '0) begin
        cnt_nx = cnt - 4'd1;
      end else begin
        memdat_nx = rd_data;
        state_nx  = READY;
        if (served_oor) begin
          err_nx = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Self-checking bench: directed vector table, reset/burst sequences, and a
// randomized phase compared against a cycle-counting reference model.
module tb_instruction_memory_responder;

  localparam int unsigned ADDR_BITS = 10;
  localparam int unsigned LATENCY   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [15:0] memdat;
  logic        wt;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [15:0] ld_data;
  logic        err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  instruction_memory_responder #(
    .ADDR_BITS(ADDR_BITS),
    .LATENCY  (LATENCY)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .memdat (memdat),
    .wt     (wt),
    .ld_en  (ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Reference model: counts edges since the last accepted address.
  logic [15:0] m_mem [0:(1<<ADDR_BITS)-1];
  logic [31:0] m_last;
  bit          m_valid;
  bit          m_ready;
  int unsigned m_edges;
  logic [15:0] m_data;
  bit          m_err;

  // Sampled DUT outputs and model expectations for the last applied cycle.
  logic        s_wt, e_wt, s_err, e_err;
  logic [15:0] s_md, e_md;

  function automatic bit in_range(input logic [31:0] a);
    return (a >> ADDR_BITS) == 32'd0;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_ready = 0;
    m_edges = 0;
    m_last  = '0;
    m_data  = '0;
    m_err   = 0;
  endtask

  task automatic model_edge(input logic [31:0] a, input bit le,
                            input logic [31:0] la, input logic [15:0] ld);
    bit          collide;
    logic [15:0] rd;
    collide = m_valid && le && (la == m_last);
    rd = in_range(m_last) ? m_mem[m_last[ADDR_BITS-1:0]] : 16'hFFFF;
    if (le) begin
      if (in_range(la)) m_mem[la[ADDR_BITS-1:0]] = ld;
      else m_err = 1;
    end
    if (!m_valid || a != m_last || collide) begin
      m_last  = a;
      m_valid = 1;
      m_ready = 0;
      m_edges = 0;
    end else if (!m_ready) begin
      m_edges++;
      if (m_edges == LATENCY) begin
        m_ready = 1;
        m_data  = rd;
        if (!in_range(m_last)) m_err = 1;
      end
    end
  endtask

  // One clock cycle: drive, sample mid-cycle, advance model, take the edge.
  task automatic apply(input logic [31:0] a, input bit le,
                       input logic [31:0] la, input logic [15:0] ld);
    addr    = a;
    ld_en   = le;
    ld_addr = la;
    ld_data = ld;
    @(negedge clk);
    s_wt  = wt;
    s_md  = memdat;
    s_err = err;
    e_wt  = !(m_ready && a == m_last && !(le && la == m_last));
    e_md  = m_data;
    e_err = m_err;
    model_edge(a, le, la, ld);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [31:0] a;
    bit          le;
    logic [31:0] la;
    logic [15:0] ld;
    bit          x_wt;
    logic [15:0] x_md;
    bit          x_err;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int unsigned waits;
    logic [31:0] ra;
    logic [31:0] pool [10];

    for (int i = 0; i < (1 << ADDR_BITS); i++) m_mem[i] = '0;
    rst = 1'b1; addr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wt", {31'd0, wt}, 32'd1);
    chk("reset_memdat", {16'd0, memdat}, 32'h0);
    chk("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    // Loads, basic read, abort, collision, far load, out-of-range read.
    vecs = '{
      '{32'h0,        1, 32'h10, 16'hBEEF, 1, 16'h0000, 0},
      '{32'h0,        1, 32'h11, 16'h1234, 1, 16'h0000, 0},
      '{32'h10,       0, 32'h0,  16'h0,    1, 16'h0000, 0},
      '{32'h10,       0, 32'h0,  16'h0,    1, 16'h0000, 0},
      '{32'h10,       0, 32'h0,  16'h0,    1, 16'h0000, 0},
      '{32'h10,       0, 32'h0,  16'h0,    0, 16'hBEEF, 0},
      '{32'h11,       0, 32'h0,  16'h0,    1, 16'hBEEF, 0},
      '{32'h11,       0, 32'h0,  16'h0,    1, 16'hBEEF, 0},
      '{32'h11,       0, 32'h0,  16'h0,    1, 16'hBEEF, 0},
      '{32'h11,       0, 32'h0,  16'h0,    0, 16'h1234, 0},
      '{32'h10,       0, 32'h0,  16'h0,    1, 16'h1234, 0},
      '{32'h11,       0, 32'h0,  16'h0,    1, 16'h1234, 0},
      '{32'h11,       0, 32'h0,  16'h0,    1, 16'h1234, 0},
      '{32'h11,       0, 32'h0,  16'h0,    1, 16'h1234, 0},
      '{32'h11,       0, 32'h0,  16'h0,    0, 16'h1234, 0},
      '{32'h10,       0, 32'h0,  16'h0,    1, 16'h1234, 0},
      '{32'h10,       0, 32'h0,  16'h0,    1, 16'h1234, 0},
      '{32'h10,       0, 32'h0,  16'h0,    1, 16'h1234, 0},
      '{32'h10,       0, 32'h0,  16'h0,    0, 16'hBEEF, 0},
      '{32'h10,       1, 32'h10, 16'hCAFE, 1, 16'hBEEF, 0},
      '{32'h10,       0, 32'h0,  16'h0,    1, 16'hBEEF, 0},
      '{32'h10,       0, 32'h0,  16'h0,    1, 16'hBEEF, 0},
      '{32'h10,       0, 32'h0,  16'h0,    0, 16'hCAFE, 0},
      '{32'h10,       1, 32'h40, 16'h5555, 0, 16'hCAFE, 0},
      '{32'h10,       0, 32'h0,  16'h0,    0, 16'hCAFE, 0},
      '{32'hF0000000, 0, 32'h0,  16'h0,    1, 16'hCAFE, 0},
      '{32'hF0000000, 0, 32'h0,  16'h0,    1, 16'hCAFE, 0},
      '{32'hF0000000, 0, 32'h0,  16'h0,    1, 16'hCAFE, 0},
      '{32'hF0000000, 0, 32'h0,  16'h0,    0, 16'hFFFF, 1},
      '{32'h10,       0, 32'h0,  16'h0,    1, 16'hFFFF, 1},
      '{32'h10,       0, 32'h0,  16'h0,    1, 16'hFFFF, 1},
      '{32'h10,       0, 32'h0,  16'h0,    1, 16'hFFFF, 1},
      '{32'h10,       0, 32'h0,  16'h0,    0, 16'hCAFE, 1}
    };
    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].le, vecs[i].la, vecs[i].ld);
      chk($sformatf("vec%0d_wt", i), {31'd0, s_wt}, {31'd0, vecs[i].x_wt});
      chk($sformatf("vec%0d_memdat", i), {16'd0, s_md}, {16'd0, vecs[i].x_md});
      chk($sformatf("vec%0d_err", i), {31'd0, s_err}, {31'd0, vecs[i].x_err});
    end

    // Reset in the middle of a fetch, then the full latency from scratch.
    apply(32'h11, 0, 32'h0, 16'h0);
    rst = 1'b1;
    #1;
    chk("midrst_wt", {31'd0, wt}, 32'd1);
    chk("midrst_memdat", {16'd0, memdat}, 32'h0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply(32'h11, 0, 32'h0, 16'h0);
      chk($sformatf("postrst%0d_wt", i), {31'd0, s_wt}, (i < 3) ? 32'd1 : 32'd0);
    end
    chk("postrst_memdat", {16'd0, s_md}, 32'h1234);

    // Cache burst: advance the address each time wt=0 is sampled.
    for (int i = 0; i < 4; i++) apply(32'h11, 1, 32'h20 + i, 16'hA000 + 16'(i));
    for (int w = 0; w < 4; w++) begin
      waits = 0;
      apply(32'h20 + w, 0, 32'h0, 16'h0);
      while (s_wt && waits < 20) begin
        waits++;
        apply(32'h20 + w, 0, 32'h0, 16'h0);
      end
      // wt is high on the acceptance edge and on LATENCY edges after it.
      chk($sformatf("burst%0d_waits", w), waits, LATENCY + 1);
      chk($sformatf("burst%0d_memdat", w), {16'd0, s_md}, 32'hA000 + w);
      chk($sformatf("burst%0d_err", w), {31'd0, s_err}, 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 8; i++) apply(32'h23, 1, 32'h10 + i, 16'($urandom));
    for (int i = 0; i < 8; i++) pool[i] = 32'h10 + i;
    pool[8] = 32'hF0000000;
    pool[9] = 32'h400;
    ra = pool[0];
    for (int i = 0; i < 400; i++) begin
      bit          le;
      logic [31:0] la;
      if ($urandom_range(3) == 0) ra = pool[$urandom_range(9)];
      le = ($urandom_range(4) == 0);
      la = ($urandom_range(2) == 0) ? ra : pool[$urandom_range(9)];
      apply(ra, le, la, 16'($urandom));
      chk($sformatf("rnd%0d_wt", i), {31'd0, s_wt}, {31'd0, e_wt});
      chk($sformatf("rnd%0d_memdat", i), {16'd0, s_md}, {16'd0, e_md});
      chk($sformatf("rnd%0d_err", i), {31'd0, s_err}, {31'd0, e_err});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_memory_responder.md
Name: instruction_memory_responder

Overview:
- Memory-side responder for the instruction cache's 16-bit fetch interface.
- The cache drives a 32-bit word address and samples `memdat` on the first clock edge where `wt` is low.
- This block holds a word-addressed instruction store and answers each new address after a fixed latency, holding `wt` high until the data is valid.
- A load port writes the program image into the store.

Parameters:
- ADDR_BITS, 10: implemented address bits. The store is 2^ADDR_BITS words of 16 bits.
- LATENCY, 2: clock edges from address acceptance to data valid. Legal range is 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- addr  input  32  fetch word address from the instruction cache.
- memdat  output  16  fetch data; valid while `wt`=0.
- wt  output  1  wait; high means `memdat` does not correspond to `addr`.
- ld_en  input  1  load-port write strobe, sampled on the clock edge.
- ld_addr  input  32  load-port word address.
- ld_data  input  16  load-port write data.
- err  output  1  sticky flag: an out-of-range read or load has occurred.

Behaviour:
- Reset (asynchronous, any state, including mid-fetch):
  - state=FETCH with no valid served address; pending fetch discarded.
  - memdat=16'h0000, err=0, wt=1.
  - Store contents are not cleared.
- Registers:
  - `served_addr` (32 bit), `served_valid`, `state` ∈ {FETCH, READY}, latency counter `cnt` (4 bit), `memdat` (registered).
- `wt` is combinational: wt = (state≠READY) OR (addr≠served_addr) OR (ld_en AND ld_addr==served_addr).
  - So `wt` rises in the same cycle the cache presents a new address; stale data is never sampled.
- Acceptance edge E0: any edge where addr≠served_addr or served_valid=0.
  - served_addr←addr, served_valid←1, state←FETCH, cnt←LATENCY-1.
- FETCH:
  - Each edge with unchanged addr and cnt≠0: cnt←cnt-1.
  - Edge with cnt==0: memdat←read data, state←READY.
  - Net effect: `wt` falls immediately after edge E0+LATENCY; `memdat` is valid from then.
- Address change during FETCH:
  - Abort and treat that edge as a new E0 (restart the full latency).
  - No partial data is ever presented.
- READY:
  - `memdat` holds the data; `wt`=0 as long as addr==served_addr and no conflicting load.
  - A new address causes acceptance on the next edge.
- Read data and range:
  - Read data = store[addr[ADDR_BITS-1:0]] when addr[31:ADDR_BITS]==0.
  - Otherwise the read returns 16'hFFFF and sets err←1 at the completion edge.
  - This covers the cache's invalid tag 32'hF0000000.
- Load port:
  - On an edge with ld_en=1 and ld_addr in range: store[ld_addr]←ld_data.
  - Out-of-range load: write ignored, err←1.
- Load/fetch collision: ld_en with ld_addr==served_addr in any state.
  - The write completes at that edge; the fetch restarts as a new E0.
  - The returned data is the newly written value.
- A load to any other address does not disturb an in-progress or completed fetch.
- `err` clears only on reset.
- No retained read data bypasses the latency, even when the same address is re-requested after an intervening address.

Test Plan:
- Reset mid-fetch: set addr=0x10, assert rst after one edge → wt=1, memdat=0x0000, err=0. After release, the full LATENCY restarts.
- Basic read (LATENCY=2): load store[0x10]=0xBEEF, store[0x11]=0x1234; drive addr=0x10 → wt high for exactly 2 edges, then wt=0, memdat=0xBEEF. Then addr=0x11 → wt rises the same cycle, falls 2 edges later, memdat=0x1234.
- Abort: addr=0x10; one edge later addr=0x11 → wt stays high, memdat never shows 0xBEEF, wt falls 2 edges after the change with memdat=0x1234.
- Out of range: addr=0xF0000000 → after 2 edges wt=0, memdat=0xFFFF, err=1. err stays 1 after reading addr=0x10 (0xBEEF) until rst.
- Load collision: READY at addr=0x10; pulse ld_en, ld_addr=0x10, ld_data=0xCAFE → wt=1 in that cycle, falls 2 edges later with memdat=0xCAFE. A load to 0x40 in READY leaves wt=0.
- Cache burst: preload 0x20..0x23 = 0xA000..0xA003; step addr by 1 each time wt=0 is sampled → four words returned in order, each with exactly LATENCY wait edges, err=0.
